ac97_frame_tx: RTL and testbench
================================

Name: ac97_frame_tx

Overview:
- Transmit end of the sound path. Consumes the mixed 20-bit left/right samples produced by the sound channels and the sound mixer.
- Serialises them, together with an optional codec register command, into 256-bit AC'97 output frames on SDATA_OUT/SYNC.
- Generates the once-per-frame strobe that the channel waveform generators use to present their next sample.
- Sits between the sound mixer and the board's AC'97 codec pins.

Parameters:
- STARTUP_CYCLES, 512, clock cycles after reset with SYNC/SDATA held low before the first frame.

Ports:
- I_BITCLK  in  1  AC'97 bit clock (12.288 MHz); sole clock, all logic on rising edge.
- I_RESET  in  1  asynchronous, active-high reset.
- I_LEFT_SAMPLE  in  20  left PCM sample, two's complement; captured at frame load.
- I_RIGHT_SAMPLE  in  20  right PCM sample, two's complement; captured at frame load.
- I_CMD_VALID  in  1  codec register command offered.
- I_CMD_RD  in  1  1 = register read, 0 = register write.
- I_CMD_ADDR  in  7  codec register index.
- I_CMD_DATA  in  16  write data; ignored for reads.
- O_CMD_READY  out  1  command slot free; accept on I_CMD_VALID & O_CMD_READY.
- O_STROBE  out  1  one-cycle pulse, one per frame; samples must be stable by the next edge.
- O_SYNC  out  1  AC'97 SYNC, registered.
- O_SDATA_OUT  out  1  AC'97 serial data, MSB first, registered.

Behaviour:
- Reset (async, immediate): O_SYNC=0, O_SDATA_OUT=0, O_STROBE=0, O_CMD_READY=1, pending command cleared, bit counter=0, state=WAIT, startup counter=0.
- The state machine has two states: WAIT and RUN.
- WAIT:
  - Outputs held low; startup counter increments each cycle.
  - When the counter reaches STARTUP_CYCLES-1, the next edge performs the first frame load and enters RUN.
- RUN:
  - 8-bit bit counter b, 0..255, wraps 255->0 with no gap.
  - The frame-load edge is the edge on which b becomes 0 (including the first one from WAIT).
  - On that edge: L/R samples snapshot into a 256-bit frame shift register; pending command (if any) moves into the frame and pending clears.
  - O_SDATA_OUT = frame bit 255-b, valid in the cycle after the edge that set b.
  - O_SYNC = 1 for b in 0..15, else 0.
  - O_STROBE = 1 in the cycle with b==254, i.e. two cycles before frame load.
- Frame layout (bit 255 first):
  - Slot 0 tag (16 bits):
    - bit15 = 1.
    - bit14 = command present.
    - bit13 = command present & write.
    - bit12 = 1 (slot 3).
    - bit11 = 1 (slot 4).
    - bits 10:0 = 0.
  - Slot 1 (20 bits): {I_CMD_RD, I_CMD_ADDR[6:0], 12'b0}; all zero if no command.
  - Slot 2 (20 bits): {I_CMD_DATA, 4'b0} for a write, else zero.
  - Slot 3 = left sample; slot 4 = right sample.
  - Slots 5-12 = zero.
- Command handshake:
  - O_CMD_READY = ~pending.
  - Accept edge: pending set, ADDR/DATA/RD captured, READY falls the cycle after.
  - A command accepted on the frame-load edge is not in that frame; it goes in the next.
  - READY returns high the cycle after the frame load that consumes the command.
  - Only one command per frame.
- Sample inputs are sampled only at frame load; changes at any other time have no effect on the frame being shifted.
- Reset asserted mid-frame: frame is abandoned, outputs low immediately, full STARTUP_CYCLES wait repeats after release.

Optional Feature:
- AC97_CMD_SLOT_EN:
  - Defined: command path as above.
  - Undefined: O_CMD_READY tied 0, no pending register; tag bits 14/13 and slots 1-2 always zero; command inputs ignored.

Test Plan:
- Reset, release -> O_SYNC/O_SDATA_OUT stay 0 for 512 cycles; first SYNC high on cycle 513, lasting exactly 16 cycles, repeating every 256 cycles.
- LEFT=20'h80001, RIGHT=20'h7FFFE held -> tag stream 16'h9800; slot 3 bits = 1000_0000_0000_0000_0001; slot 4 bits = 0111_1111_1111_1111_1110; slots 5-12 all 0.
- O_STROBE checked -> single pulse at b==254 each frame; change LEFT from 1 to 2 on the strobe cycle -> next frame carries 2.
- Write cmd ADDR=7'h02, DATA=16'h0808 accepted mid-frame -> next frame: tag 16'hF800, slot 1 = 20'h02000, slot 2 = 20'h08080; READY low until that frame load, then high.
- Read cmd ADDR=7'h26 accepted on the frame-load edge -> not in the current frame; following frame tag 16'hD800, slot 1 = 20'hA6000, slot 2 = 0.
- Reset asserted at b==100 -> outputs 0 at once, READY=1, pending lost; after release, the startup wait is 512 cycles again.
- Build without AC97_CMD_SLOT_EN, offer command -> READY stays 0, tag 16'h9800.

Source files
------------

// File: rtl/ac97_frame_tx_if.sv
// ac97_frame_tx_if: sample and command inputs plus AC'97 pin outputs of the frame transmitter
interface ac97_frame_tx_if;
  logic [19:0] I_LEFT_SAMPLE;
  logic [19:0] I_RIGHT_SAMPLE;
  logic        I_CMD_VALID;
  logic        I_CMD_RD;
  logic [6:0]  I_CMD_ADDR;
  logic [15:0] I_CMD_DATA;
  logic        O_CMD_READY;
  logic        O_STROBE;
  logic        O_SYNC;
  logic        O_SDATA_OUT;
  modport master (
    output I_LEFT_SAMPLE, I_RIGHT_SAMPLE, I_CMD_VALID, I_CMD_RD, I_CMD_ADDR, I_CMD_DATA,
    input  O_CMD_READY, O_STROBE, O_SYNC, O_SDATA_OUT
  );
  modport slave (
    input  I_LEFT_SAMPLE, I_RIGHT_SAMPLE, I_CMD_VALID, I_CMD_RD, I_CMD_ADDR, I_CMD_DATA,
    output O_CMD_READY, O_STROBE, O_SYNC, O_SDATA_OUT
  );
endinterface

// File: rtl/ac97_frame_tx.sv
// ac97_frame_tx: AC'97 256-bit output frame serialiser with per-frame sample strobe; define AC97_CMD_SLOT_EN to carry codec register commands in slots 1-2
module ac97_frame_tx #(
  parameter int STARTUP_CYCLES = 512
) (
  input logic            I_BITCLK,
  input logic            I_RESET,
  ac97_frame_tx_if.slave bus
);
  localparam int CW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  typedef enum logic {WAIT, RUN} state_t;
  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [7:0]     r_b, w_b_nxt;
  logic           w_load;
  logic [254:0]   r_sr;
  logic [255:0]   w_frame;
  logic           r_sync, r_sdata, r_strobe;
  logic           w_cp, w_cmd_rd;
  logic [6:0]     w_cmd_addr;
  logic [15:0]    w_cmd_data;

  assign w_frame = {1'b1, w_cp, w_cp & ~w_cmd_rd, 2'b11, 11'd0,
                    w_cp ? {w_cmd_rd, w_cmd_addr, 12'd0} : 20'd0,
                    (w_cp & ~w_cmd_rd) ? {w_cmd_data, 4'd0} : 20'd0,
                    bus.I_LEFT_SAMPLE, bus.I_RIGHT_SAMPLE, 160'd0};

  // frame load happens at the end of the startup wait and on every 255->0 wrap
  always_comb begin
    w_load      = (r_state == WAIT) ? (r_cnt == CW'(STARTUP_CYCLES - 1)) : (r_b == 8'd255);
    w_state_nxt = (r_state == RUN || w_load) ? RUN : WAIT;
    w_b_nxt     = (r_state == RUN) ? r_b + 8'd1 : 8'd0;
  end

  // state register
  always_ff @(posedge I_BITCLK or posedge I_RESET) begin
    if (I_RESET) r_state <= WAIT;
    else         r_state <= w_state_nxt;
  end

  // startup counter, bit counter, frame shifter and registered pin outputs
  always_ff @(posedge I_BITCLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_cnt    <= '0;
      r_b      <= 8'd0;
      r_sr     <= '0;
      r_sdata  <= 1'b0;
      r_sync   <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_cnt    <= (r_state == WAIT) ? r_cnt + CW'(1) : r_cnt;
      r_b      <= w_b_nxt;
      r_sr     <= w_load ? w_frame[254:0] : {r_sr[253:0], 1'b0};
      r_sdata  <= (w_state_nxt == RUN) && (w_load ? w_frame[255] : r_sr[254]);
      r_sync   <= (w_state_nxt == RUN) && (w_b_nxt < 8'd16);
      r_strobe <= (r_state == RUN) && (w_b_nxt == 8'd254);
    end
  end

  assign bus.O_SYNC      = r_sync;
  assign bus.O_SDATA_OUT = r_sdata;
  assign bus.O_STROBE    = r_strobe;

`ifdef AC97_CMD_SLOT_EN
  logic        r_pend, r_rd;
  logic [6:0]  r_addr;
  logic [15:0] r_data;

  // one pending command: captured on accept, consumed by the next frame load
  always_ff @(posedge I_BITCLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_pend <= 1'b0;
      r_rd   <= 1'b0;
      r_addr <= 7'd0;
      r_data <= 16'd0;
    end else begin
      if (bus.I_CMD_VALID && !r_pend) begin
        r_rd   <= bus.I_CMD_RD;
        r_addr <= bus.I_CMD_ADDR;
        r_data <= bus.I_CMD_DATA;
      end
      r_pend <= (bus.I_CMD_VALID && !r_pend) || (r_pend && !w_load);
    end
  end

  assign w_cp            = r_pend;
  assign w_cmd_rd        = r_rd;
  assign w_cmd_addr      = r_addr;
  assign w_cmd_data      = r_data;
  assign bus.O_CMD_READY = ~r_pend;
`else
  logic w_unused;
  assign w_unused        = ^{bus.I_CMD_VALID, bus.I_CMD_RD, bus.I_CMD_ADDR, bus.I_CMD_DATA};
  assign w_cp            = 1'b0;
  assign w_cmd_rd        = 1'b0;
  assign w_cmd_addr      = 7'd0;
  assign w_cmd_data      = 16'd0;
  assign bus.O_CMD_READY = 1'b0;
`endif
endmodule

// File: tb/tb_ac97_frame_tx.sv
// tb_ac97_frame_tx: randomized self-checking bench comparing captured AC'97 frames against a slot-level frame model
module tb_ac97_frame_tx;
`ifdef AC97_CMD_SLOT_EN
  localparam bit CMD_EN = 1'b1;
`else
  localparam bit CMD_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int n_wait;
  logic [255:0] fr, fsync, fstb, frdy, e, m;
  logic [19:0] cl, cr, ex_l, ex_r;

  ac97_frame_tx_if bus();
  ac97_frame_tx #(.STARTUP_CYCLES(512)) dut (.I_BITCLK(clk), .I_RESET(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // expected frame assembled slot by slot: slot 0 is 16 bits, slots 1-12 are 20 bits, MSB first
  function automatic logic [255:0] model(input logic [19:0] l, input logic [19:0] r, input bit cp,
                                         input bit rd, input logic [6:0] a, input logic [15:0] d);
    logic [19:0] slot [0:12];
    logic [255:0] f;
    int p;
    for (int s = 0; s < 13; s++) slot[s] = 20'd0;
    slot[0] = {4'd0, 1'b1, cp, cp & ~rd, 2'b11, 11'd0};
    if (cp) slot[1] = {rd, a, 12'd0};
    if (cp && !rd) slot[2] = {d, 4'd0};
    slot[3] = l;
    slot[4] = r;
    f = '0;
    p = 255;
    for (int s = 0; s < 13; s++)
      for (int k = (s == 0) ? 15 : 19; k >= 0; k--) begin
        f[p] = slot[s][k];
        p--;
      end
    return f;
  endfunction

  function automatic logic [255:0] sync_pattern();
    logic [255:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = 1'b1;
    return v;
  endfunction

  // capture one frame starting at its b==0 cycle; new samples applied in the strobe cycle
  task automatic get_frame(input logic [19:0] nl, input logic [19:0] nr, input int cmd_at,
                           input bit hold, input bit at_rise);
    logic prev;
    n_wait = 0;
    prev = bus.O_SYNC;
    if (!at_rise) begin
      for (n_wait = 1; n_wait <= 2000; n_wait++) begin
        @(negedge clk);
        if (bus.O_SYNC && !prev) break;
        prev = bus.O_SYNC;
      end
      if (n_wait > 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL frame_align: no SYNC rise seen, required one within 2000 cycles");
      end
    end
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      fr[255-i] = bus.O_SDATA_OUT;
      fsync[i] = bus.O_SYNC;
      fstb[i] = bus.O_STROBE;
      frdy[i] = bus.O_CMD_READY;
      if (i == 254) begin
        bus.I_LEFT_SAMPLE = nl;
        bus.I_RIGHT_SAMPLE = nr;
      end
      bus.I_CMD_VALID = hold || (i == cmd_at);
    end
    ex_l = cl;
    ex_r = cr;
    cl = nl;
    cr = nr;
  endtask

  task automatic count_startup(input string tag);
    int n;
    bit quiet;
    quiet = 1'b1;
    for (n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (bus.O_SYNC) break;
      if (bus.O_SDATA_OUT !== 1'b0 || bus.O_STROBE !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (n !== 512) begin
      n_err++;
      $display("FAIL %s_startup_len: first SYNC after %0d edges, required 512", tag, n);
    end
    n_cmp++;
    if (quiet !== 1'b1) begin
      n_err++;
      $display("FAIL %s_startup_quiet: SDATA/STROBE active during wait, required low", tag);
    end
  endtask

  task automatic test_reset();
    bus.I_LEFT_SAMPLE = 20'h80001;
    bus.I_RIGHT_SAMPLE = 20'h7FFFE;
    cl = 20'h80001;
    cr = 20'h7FFFE;
    bus.I_CMD_VALID = 1'b0;
    bus.I_CMD_RD = 1'b0;
    bus.I_CMD_ADDR = 7'd0;
    bus.I_CMD_DATA = 16'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.O_SYNC !== 1'b0) begin n_err++; $display("FAIL reset_sync: got %b, required 0", bus.O_SYNC); end
    n_cmp++;
    if (bus.O_SDATA_OUT !== 1'b0) begin n_err++; $display("FAIL reset_sdata: got %b, required 0", bus.O_SDATA_OUT); end
    n_cmp++;
    if (bus.O_STROBE !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b, required 0", bus.O_STROBE); end
    n_cmp++;
    if (bus.O_CMD_READY !== CMD_EN) begin n_err++; $display("FAIL reset_ready: got %b, required %b", bus.O_CMD_READY, CMD_EN); end
    rst = 1'b0;
    count_startup("init");
    get_frame(cl, cr, -1, 1'b0, 1'b1);
    m = model(ex_l, ex_r, 1'b0, 1'b0, 7'd0, 16'd0);
    n_cmp++;
    if (fr !== m) begin n_err++; $display("FAIL first_frame: got %h, required %h", fr, m); end
  endtask

  task automatic test_sync_timing();
    get_frame(cl, cr, -1, 1'b0, 1'b0);
    n_cmp++;
    if (n_wait !== 1) begin n_err++; $display("FAIL sync_period: next frame after %0d extra cycles, required 1 (256 total)", n_wait); end
    e = sync_pattern();
    n_cmp++;
    if (fsync !== e) begin n_err++; $display("FAIL sync_shape: got %h, required %h", fsync, e); end
    e = '0;
    e[254] = 1'b1;
    n_cmp++;
    if (fstb !== e) begin n_err++; $display("FAIL strobe_pos: got %h, required %h", fstb, e); end
  endtask

  task automatic test_fixed_samples();
    m = model(ex_l, ex_r, 1'b0, 1'b0, 7'd0, 16'd0);
    n_cmp++;
    if (fr !== m) begin n_err++; $display("FAIL fixed_frame: got %h, required %h", fr, m); end
    n_cmp++;
    if (fr[255:240] !== 16'h9800) begin n_err++; $display("FAIL fixed_tag: got %h, required 9800", fr[255:240]); end
    n_cmp++;
    if (fr[199:180] !== 20'b1000_0000_0000_0000_0001) begin n_err++; $display("FAIL fixed_left: got %h, required 80001", fr[199:180]); end
    n_cmp++;
    if (fr[179:160] !== 20'b0111_1111_1111_1111_1110) begin n_err++; $display("FAIL fixed_right: got %h, required 7fffe", fr[179:160]); end
    n_cmp++;
    if (fr[159:0] !== 160'd0) begin n_err++; $display("FAIL fixed_tail: got %h, required 0", fr[159:0]); end
  endtask

  task automatic test_strobe_change();
    get_frame(20'h1, cr, -1, 1'b0, 1'b0);
    get_frame(20'h2, cr, -1, 1'b0, 1'b0);
    n_cmp++;
    if (fr[199:180] !== 20'h1) begin n_err++; $display("FAIL change_left1: got %h, required 00001", fr[199:180]); end
    get_frame(20'h2, cr, -1, 1'b0, 1'b0);
    n_cmp++;
    if (fr[199:180] !== 20'h2) begin n_err++; $display("FAIL change_left2: got %h, required 00002", fr[199:180]); end
  endtask

  task automatic test_random_samples();
    for (int k = 0; k < 6; k++) begin
      get_frame(20'($urandom), 20'($urandom), -1, 1'b0, 1'b0);
      m = model(ex_l, ex_r, 1'b0, 1'b0, 7'd0, 16'd0);
      n_cmp++;
      if (fr !== m) begin n_err++; $display("FAIL rand_frame%0d: got %h, required %h", k, fr, m); end
      e = '0;
      e[254] = 1'b1;
      n_cmp++;
      if (fstb !== e || n_wait !== 1) begin n_err++; $display("FAIL rand_strobe%0d: got %h wait %0d, required %h wait 1", k, fstb, n_wait, e); end
    end
  endtask

`ifdef AC97_CMD_SLOT_EN
  task automatic test_cmd_write();
    bus.I_CMD_RD = 1'b0;
    bus.I_CMD_ADDR = 7'h02;
    bus.I_CMD_DATA = 16'h0808;
    get_frame(cl, cr, 100, 1'b0, 1'b0);
    e = '0;
    for (int i = 0; i <= 100; i++) e[i] = 1'b1;
    n_cmp++;
    if (frdy !== e) begin n_err++; $display("FAIL wr_ready_accept: got %h, required %h", frdy, e); end
    get_frame(cl, cr, -1, 1'b0, 1'b0);
    m = model(ex_l, ex_r, 1'b1, 1'b0, 7'h02, 16'h0808);
    n_cmp++;
    if (fr !== m) begin n_err++; $display("FAIL wr_frame: got %h, required %h", fr, m); end
    n_cmp++;
    if (fr[255:240] !== 16'hF800 || fr[239:220] !== 20'h02000 || fr[219:200] !== 20'h08080) begin
      n_err++;
      $display("FAIL wr_slots: got tag %h s1 %h s2 %h, required F800 02000 08080", fr[255:240], fr[239:220], fr[219:200]);
    end
    n_cmp++;
    if (frdy !== '1) begin n_err++; $display("FAIL wr_ready_after: got %h, required all ones", frdy); end
  endtask

  task automatic test_cmd_read_on_load();
    bus.I_CMD_RD = 1'b1;
    bus.I_CMD_ADDR = 7'h26;
    bus.I_CMD_DATA = 16'hFFFF;
    get_frame(cl, cr, 255, 1'b0, 1'b0);
    n_cmp++;
    if (frdy !== '1) begin n_err++; $display("FAIL rd_ready_before: got %h, required all ones", frdy); end
    get_frame(cl, cr, -1, 1'b0, 1'b0);
    n_cmp++;
    if (fr[255:240] !== 16'h9800) begin n_err++; $display("FAIL rd_not_current: got tag %h, required 9800", fr[255:240]); end
    n_cmp++;
    if (frdy !== '0) begin n_err++; $display("FAIL rd_ready_pending: got %h, required all zeros", frdy); end
    get_frame(cl, cr, -1, 1'b0, 1'b0);
    m = model(ex_l, ex_r, 1'b1, 1'b1, 7'h26, 16'hFFFF);
    n_cmp++;
    if (fr !== m) begin n_err++; $display("FAIL rd_frame: got %h, required %h", fr, m); end
    n_cmp++;
    if (fr[255:240] !== 16'hD800 || fr[239:220] !== 20'hA6000 || fr[219:200] !== 20'h0) begin
      n_err++;
      $display("FAIL rd_slots: got tag %h s1 %h s2 %h, required D800 A6000 00000", fr[255:240], fr[239:220], fr[219:200]);
    end
  endtask

  task automatic test_cmd_random();
    bit rd;
    logic [6:0] a;
    logic [15:0] d;
    for (int k = 0; k < 3; k++) begin
      rd = 1'($urandom);
      a = 7'($urandom);
      d = 16'($urandom);
      bus.I_CMD_RD = rd;
      bus.I_CMD_ADDR = a;
      bus.I_CMD_DATA = d;
      get_frame(20'($urandom), 20'($urandom), int'($urandom_range(20, 240)), 1'b0, 1'b0);
      get_frame(cl, cr, -1, 1'b0, 1'b0);
      m = model(ex_l, ex_r, 1'b1, rd, a, d);
      n_cmp++;
      if (fr !== m) begin n_err++; $display("FAIL cmd_rand%0d: got %h, required %h", k, fr, m); end
    end
  endtask
`else
  task automatic test_no_cmd();
    bus.I_CMD_RD = 1'b0;
    bus.I_CMD_ADDR = 7'h02;
    bus.I_CMD_DATA = 16'h0808;
    get_frame(cl, cr, -1, 1'b1, 1'b0);
    n_cmp++;
    if (frdy !== '0) begin n_err++; $display("FAIL nocmd_ready: got %h, required all zeros", frdy); end
    get_frame(cl, cr, -1, 1'b1, 1'b0);
    n_cmp++;
    if (fr[255:240] !== 16'h9800) begin n_err++; $display("FAIL nocmd_tag: got %h, required 9800", fr[255:240]); end
    m = model(ex_l, ex_r, 1'b0, 1'b0, 7'd0, 16'd0);
    n_cmp++;
    if (fr !== m) begin n_err++; $display("FAIL nocmd_frame: got %h, required %h", fr, m); end
    bus.I_CMD_VALID = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    logic prev;
    int n;
    bus.I_CMD_RD = 1'b0;
    bus.I_CMD_ADDR = 7'h05;
    bus.I_CMD_DATA = 16'h1234;
    prev = bus.O_SYNC;
    for (n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (bus.O_SYNC && !prev) break;
      prev = bus.O_SYNC;
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.O_SYNC !== 1'b1) begin n_err++; $display("FAIL mid5_sync_before: got %b, required 1", bus.O_SYNC); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.O_SYNC !== 1'b0) begin n_err++; $display("FAIL mid5_sync_async: got %b, required 0", bus.O_SYNC); end
    @(negedge clk);
    rst = 1'b0;
    count_startup("mid5");
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      bus.I_CMD_VALID = (i == 50);
    end
    n_cmp++;
    if (bus.O_CMD_READY !== 1'b0) begin n_err++; $display("FAIL mid100_ready_before: got %b, required 0", bus.O_CMD_READY); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.O_SYNC !== 1'b0 || bus.O_SDATA_OUT !== 1'b0 || bus.O_STROBE !== 1'b0) begin
      n_err++;
      $display("FAIL mid100_outputs: got sync %b sdata %b strobe %b, required 0 0 0", bus.O_SYNC, bus.O_SDATA_OUT, bus.O_STROBE);
    end
    n_cmp++;
    if (bus.O_CMD_READY !== CMD_EN) begin n_err++; $display("FAIL mid100_ready: got %b, required %b", bus.O_CMD_READY, CMD_EN); end
    @(negedge clk);
    rst = 1'b0;
    count_startup("mid100");
    get_frame(cl, cr, -1, 1'b0, 1'b1);
    m = model(ex_l, ex_r, 1'b0, 1'b0, 7'd0, 16'd0);
    n_cmp++;
    if (fr !== m) begin n_err++; $display("FAIL mid100_pending_lost: got %h, required %h", fr, m); end
  endtask

  initial begin
    test_reset();
    test_sync_timing();
    test_fixed_samples();
    test_strobe_change();
    test_random_samples();
`ifdef AC97_CMD_SLOT_EN
    test_cmd_write();
    test_cmd_read_on_load();
    test_cmd_random();
`else
    test_no_cmd();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
